risc6_fetch: RTL and testbench
==============================

RISC6_FETCH -- requirements
Module: risc6_fetch

Interface
REQ-001 Parameter DEPTH, default 4: prefetch FIFO entries; power of two, 2 to 16.
REQ-002 Parameter ADDR_W, default 8: instruction word-address width.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port mem_req  output  1  fetch request to instruction memory.
REQ-006 Port mem_addr  output  ADDR_W  word address of request.
REQ-007 Port mem_ack  input  1  memory response strobe; one cycle per request.
REQ-008 Port mem_rdata  input  32  instruction word, valid with mem_ack.
REQ-009 Port instr  output  32  FIFO head instruction to core.
REQ-010 Port instr_valid  output  1  instr holds a valid word.
REQ-011 Port instr_ready  input  1  core consumes head when high with instr_valid.
REQ-012 Port flush  input  1  discard prefetched words, restart at flush_addr.
REQ-013 Port flush_addr  input  ADDR_W  restart address, sampled with flush.
REQ-014 Port halted  output  1  fetch stopped after HLT word.

Function
REQ-015 FSM states: IDLE (no request outstanding), WAIT (mem_req high, awaiting mem_ack), HALTED.
REQ-016 IDLE->WAIT when not halted and FIFO count < DEPTH; mem_addr = fetch_pc in the same cycle mem_req rises.
REQ-017 mem_req and mem_addr stay stable in WAIT until mem_ack; at most one request outstanding.
REQ-018 On mem_ack: push mem_rdata, fetch_pc <= fetch_pc + 1 (mod 2^ADDR_W), go IDLE; new request earliest next cycle.
REQ-019 Pushed word appears at instr with instr_valid the cycle after mem_ack (FIFO empty case).
REQ-020 Pop on instr_valid && instr_ready; simultaneous push and pop leaves count unchanged.
REQ-021 FIFO full: no request issued; a pop reopens issue the following cycle.
REQ-022 Pushed word with opcode [31:26] = 6'b111111 (HLT): enter HALTED, halted=1, no further requests.
REQ-023 flush in IDLE/HALTED: FIFO emptied, fetch_pc <= flush_addr, halted=0, go IDLE next cycle.
REQ-024 flush in WAIT: FIFO emptied, fetch_pc <= flush_addr, request held until mem_ack, that response discarded (not pushed, no predecode).
REQ-025 flush coincident with mem_ack: response discarded; flush wins.
REQ-026 instr_valid=0 the cycle after any flush.
REQ-027 fetch_pc wraps from 2^ADDR_W-1 to 0 without error.

Reset
REQ-028 rst_n low: mem_req=0, mem_addr=0, instr=0, instr_valid=0, halted=0, fetch_pc=0, FIFO empty, state IDLE.
REQ-029 Reset during WAIT abandons the request; any mem_ack while rst_n low is ignored.
REQ-030 First request issued on first rising clk edge after rst_n deasserts.

Configuration
REQ-031 Macro RISC6_FETCH_PREDECODE_EN defined: pushed word with opcode 6'b000110 (JMP) sets fetch_pc <= mem_rdata[ADDR_W-1:0] instead of +1.
REQ-032 Macro undefined: JMP words treated as sequential; redirection only via flush.

Structure
REQ-033 Shared package risc6_pkg holds opcode constants (JMP, HLT), opcode field position, default ADDR_W and DEPTH.
REQ-034 FIFO is sub-module risc6_fetch_fifo (DEPTH, width 32, push/pop/flush, count, full/empty).

Verification
REQ-035 Reset release, memory ack 1 cycle after req, words 0x04000001..0x04000004 at 0..3, ready=1 -> addresses 0,1,2,3 in order, instr sequence matches.
REQ-036 instr_ready=0, DEPTH=4 -> exactly 4 requests (addr 0-3), mem_req stays low; one pop -> request addr 4 next cycle.
REQ-037 Word 0xFC000000 at addr 2 -> halted=1 after its ack, no request to addr 3; flush with flush_addr=0x10 -> halted=0, next request addr 0x10.
REQ-038 flush (flush_addr=0x20) while WAIT on addr 5, ack 3 cycles later -> addr 5 data never on instr, next request addr 0x20.
REQ-039 Predecode build: word 0x18000040 at addr 1 -> next request addr 0x40; non-predecode build -> addr 2.
REQ-040 flush_addr=0xFF -> requests 0xFF then 0x00 (wrap).

Source files
------------

// File: rtl/risc6_pkg.sv
// Shared definitions for the risc6 front end: opcode encodings, opcode field
// position, default fetch geometry and the fetch FSM state type.
package risc6_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 4;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    localparam logic [5:0] OPC_JMP = 6'b000110;
    localparam logic [5:0] OPC_HLT = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/risc6_fetch_fifo.sv
// Prefetch FIFO: power-of-two depth ring buffer with synchronous flush.
// The head word is presented combinationally and reads as zero when empty.
module risc6_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/risc6_fetch.sv
// risc6 instruction fetch unit: one outstanding memory request feeding a prefetch
// FIFO, with HLT stop and flush restart. Define RISC6_FETCH_PREDECODE_EN to follow JMP words.
module risc6_fetch
    import risc6_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      flush_addr,
    output logic                   halted,
    output logic [1:0]             dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);

    fetch_state_e                state;
    logic [ADDR_W-1:0]           fetch_pc;
    logic [ADDR_W-1:0]           next_pc;
    logic                        discard;
    logic                        push;
    logic                        pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(DEPTH):0]      fifo_count;
    logic [5:0]                  ack_opc;

    assign ack_opc     = opcode_of(mem_rdata);
    assign push        = (state == ST_WAIT) && mem_ack && !discard && !flush;
    assign pop         = instr_valid && instr_ready;
    assign instr_valid = !fifo_empty;
    assign dbg_state   = state;
    assign dbg_count   = fifo_count;

    always_comb begin
        next_pc = fetch_pc + ADDR_W'(1);
`ifdef RISC6_FETCH_PREDECODE_EN
        if (ack_opc == OPC_JMP) next_pc = mem_rdata[ADDR_W-1:0];
`endif
    end

    // discard marks the in-flight response as stale after a flush taken in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            fetch_pc <= '0;
            discard  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        fetch_pc <= flush_addr;
                    end else if (!fifo_full) begin
                        state    <= ST_WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                        if (flush || discard) begin
                            state <= ST_IDLE;
                            if (flush) fetch_pc <= flush_addr;
                        end else begin
                            fetch_pc <= next_pc;
                            if (ack_opc == OPC_HLT) begin
                                state  <= ST_HALTED;
                                halted <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end else if (flush) begin
                        discard  <= 1'b1;
                        fetch_pc <= flush_addr;
                    end
                end
                ST_HALTED: begin
                    if (flush) begin
                        state    <= ST_IDLE;
                        halted   <= 1'b0;
                        fetch_pc <= flush_addr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    risc6_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (mem_rdata),
        .pop   (pop),
        .flush (flush),
        .dout  (instr),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_risc6_fetch.sv
// Directed bench for risc6_fetch: a latency-programmable memory responder, request
// and instruction scoreboards fed by the stimulus, and a one-line summary.
module tb_risc6_fetch;
    import risc6_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam logic [31:0] HLT_W = 32'hFC00_0000;
    localparam logic [31:0] JMP_W = 32'h1800_0040;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W-1:0] flush_addr = '0;
    logic              halted;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_count;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_instr_q[$];
    logic [31:0]       img[256];
    int                lat = 1;
    int                wait_cnt = 0;
    logic              req_prev = 1'b0;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_instr;

    risc6_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .halted      (halted),
        .dbg_state   (dbg_state),
        .dbg_count   (dbg_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // memory responder: ack 'lat' sampled cycles after the request becomes visible
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_req) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = img[mem_addr];
            end
        end
    end

    // request monitor: every new request must match the next expected address
    always @(negedge clk) begin
        if (rst_n && mem_req && !req_prev) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected actual=%0h required=none", mem_addr);
            end else begin
                e_addr = exp_addr_q.pop_front();
                check("req_addr", mem_addr, e_addr);
            end
        end
        req_prev = mem_req;
    end

    // instruction monitor: every consumed word must match the next expected word
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_instr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL instr_unexpected actual=%0h required=none", instr);
            end else begin
                e_instr = exp_instr_q.pop_front();
                check("instr", instr, e_instr);
            end
        end
    end

    // driver tasks; callers are positioned 2 time units after a rising edge
    task automatic do_flush(input logic [ADDR_W-1:0] a);
        flush      = 1'b1;
        flush_addr = a;
        @(posedge clk); #2;
        flush      = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        check(name, halted, 1'b1);
    endtask

    task automatic settle(input string name);
        repeat (10) @(posedge clk);
        #2;
        check({name, "_req_idle"}, mem_req, 1'b0);
        check({name, "_addr_q_left"}, exp_addr_q.size(), 0);
        check({name, "_instr_q_left"}, exp_instr_q.size(), 0);
    endtask

    task automatic expect_run(input logic [ADDR_W-1:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(start + ADDR_W'(i));
            exp_instr_q.push_back(img[start + ADDR_W'(i)]);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) img[a] = 32'h0400_0000 + 32'(a) + 32'd1;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_instr", instr, '0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);

        // sequential fetch 0..3, HLT at 4 stops it
        img[4] = HLT_W;
        instr_ready = 1'b1;
        expect_run(8'h00, 5);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 8'h00);
        wait_halted("t0_halted");
        settle("t0");
        check("t0_instr_valid", instr_valid, 1'b0);

        // HLT at 2, then flush to 0x10 restarts
        img[4] = 32'h0400_0005;
        img[2] = HLT_W;
        expect_run(8'h00, 3);
        do_flush(8'h00);
        wait_halted("t1_halted");
        settle("t1");
        img[8'h13] = HLT_W;
        expect_run(8'h10, 4);
        do_flush(8'h10);
        check("t1_unhalt", halted, 1'b0);
        check("t1_flush_valid", instr_valid, 1'b0);
        wait_halted("t1b_halted");
        settle("t1b");

        // FIFO full with core stalled, one pop reopens issue
        img[2]     = 32'h0400_0003;
        img[8'h13] = 32'h0400_0014;
        instr_ready = 1'b0;
        exp_addr_q.push_back(8'h00);
        exp_addr_q.push_back(8'h01);
        exp_addr_q.push_back(8'h02);
        exp_addr_q.push_back(8'h03);
        do_flush(8'h00);
        repeat (30) @(posedge clk);
        #2;
        check("t2_full_req", mem_req, 1'b0);
        check("t2_full_count", dbg_count, 3'd4);
        check("t2_head", instr, 32'h0400_0001);
        check("t2_addr_q_left", exp_addr_q.size(), 0);
        exp_addr_q.push_back(8'h04);
        exp_instr_q.push_back(32'h0400_0001);
        instr_ready = 1'b1;
        @(posedge clk); #2;
        instr_ready = 1'b0;
        check("t2_pop_count", dbg_count, 3'd3);
        check("t2_pop_no_req_yet", mem_req, 1'b0);
        @(posedge clk); #2;
        check("t2_reissue_req", mem_req, 1'b1);
        check("t2_reissue_addr", mem_addr, 8'h04);
        repeat (10) @(posedge clk);
        #2;
        check("t2_refill_count", dbg_count, 3'd4);
        check("t2_new_head", instr, 32'h0400_0002);
        check("t2_instr_q_left", exp_instr_q.size(), 0);

        // flush while waiting on addr 5: its data is dropped, restart at 0x20
        lat = 3;
        img[8'h22] = HLT_W;
        exp_addr_q.push_back(8'h05);
        do_flush(8'h05);
        check("t3_flush_valid", instr_valid, 1'b0);
        instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_addr == 8'h05) break;
            @(posedge clk); #2;
        end
        check("t3_wait_addr", mem_addr, 8'h05);
        expect_run(8'h20, 3);
        do_flush(8'h20);
        check("t3_hold_req", mem_req, 1'b1);
        check("t3_hold_addr", mem_addr, 8'h05);
        check("t3_flush_valid2", instr_valid, 1'b0);
        wait_halted("t3_halted");
        settle("t3");

        // flush coincident with the ack: response dropped, flush target wins
        lat = 2;
        img[8'h22] = 32'h0400_0023;
        img[8'h31] = HLT_W;
        exp_addr_q.push_back(8'h08);
        exp_addr_q.push_back(8'h30);
        exp_addr_q.push_back(8'h31);
        exp_instr_q.push_back(img[8'h30]);
        exp_instr_q.push_back(HLT_W);
        do_flush(8'h08);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ack) break;
        end
        check("t4_ack_seen", mem_ack, 1'b1);
        flush      = 1'b1;
        flush_addr = 8'h30;
        @(posedge clk); #2;
        flush      = 1'b0;
        check("t4_flush_valid", instr_valid, 1'b0);
        check("t4_idle_after", mem_req, 1'b0);
        wait_halted("t4_halted");
        settle("t4");

        // address wrap 0xFF -> 0x00
        lat = 1;
        img[8'h31] = 32'h0400_0032;
        img[1] = HLT_W;
        exp_addr_q.push_back(8'hFF);
        exp_addr_q.push_back(8'h00);
        exp_addr_q.push_back(8'h01);
        exp_instr_q.push_back(32'h0400_0100);
        exp_instr_q.push_back(32'h0400_0001);
        exp_instr_q.push_back(HLT_W);
        do_flush(8'hFF);
        wait_halted("t5_halted");
        settle("t5");

        // JMP word at addr 1
        img[1] = JMP_W;
        exp_addr_q.push_back(8'h00);
        exp_addr_q.push_back(8'h01);
        exp_instr_q.push_back(32'h0400_0001);
        exp_instr_q.push_back(JMP_W);
        exp_instr_q.push_back(HLT_W);
`ifdef RISC6_FETCH_PREDECODE_EN
        img[8'h40] = HLT_W;
        exp_addr_q.push_back(8'h40);
`else
        img[2] = HLT_W;
        exp_addr_q.push_back(8'h02);
`endif
        do_flush(8'h00);
        wait_halted("t6_halted");
        settle("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
